// File: rtl/dqn_pkg.sv
// Shared DQN fixed-point helpers, mode encodings and output-stage FSM states.
package dqn_pkg;

    localparam int unsigned DQN_FRAC_BITS = 16;

    localparam logic MODE_MAX    = 1'b0;
    localparam logic MODE_SELECT = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WAIT_CTX,
        S_MUL,
        S_ADD,
        S_OUT
    } tq_state_t;

    // Signed add of two sign-extended words, clamped to a w-bit signed range (w <= 63).
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int unsigned        w
    );
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/q_argmax_acc.sv
// Running max / argmax accumulator over an in-order stream of signed Q-values.
// Strict greater-than compare, so on ties the earliest (lowest) index is kept.
module q_argmax_acc
    import dqn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic                         i_first,
    input  logic [IDX_WIDTH-1:0]         i_idx,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic signed [DATA_WIDTH-1:0] o_max,
    output logic [IDX_WIDTH-1:0]         o_idx
);

    logic signed [DATA_WIDTH-1:0] r_max;
    logic [IDX_WIDTH-1:0]         r_idx;

    // First sample of a frame seeds the max; later samples replace it only if strictly larger.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (i_valid && (i_first || (i_data > r_max))) begin
            r_max <= i_data;
            r_idx <= i_idx;
        end
    end

    assign o_max = r_max;
    assign o_idx = r_idx;

endmodule

// File: rtl/target_q_reduce.sv
// Target-network output stage: reduces a frame of Q-values (max or select-by-action)
// and computes the saturated Bellman target y = reward + gamma*Q (or reward when done).
module target_q_reduce
    import dqn_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH            = 32,
    parameter  int unsigned FRAC_BITS             = DQN_FRAC_BITS,
    parameter  int unsigned NUMBER_OF_OUTPUT_NODE = 3,
    parameter  int unsigned GAMMA                 = 62259,
    localparam int unsigned ACTION_WIDTH          = $clog2(NUMBER_OF_OUTPUT_NODE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_data_valid,
    input  logic [ACTION_WIDTH-1:0] i_data_addr,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_ready,
    input  logic                    i_ctx_valid,
    input  logic                    i_mode,
    input  logic [ACTION_WIDTH-1:0] i_action,
    input  logic [DATA_WIDTH-1:0]   i_reward,
    input  logic                    i_done,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_q,
    output logic [ACTION_WIDTH-1:0] o_action,
    output logic [DATA_WIDTH-1:0]   o_target,
    output logic                    o_err
);

    localparam int unsigned PW        = 2 * DATA_WIDTH;
    localparam int unsigned BUF_DEPTH = 1 << ACTION_WIDTH;
    localparam logic [ACTION_WIDTH-1:0] LAST_ADDR = ACTION_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

    tq_state_t r_state;
    tq_state_t w_state_nxt;

    logic [ACTION_WIDTH-1:0] r_cnt;

    logic                         r_ctx_held;
    logic                         r_mode;
    logic [ACTION_WIDTH-1:0]      r_action;
    logic signed [DATA_WIDTH-1:0] r_reward;
    logic                         r_done;

    logic signed [DATA_WIDTH-1:0] r_qbuf [BUF_DEPTH];

    logic signed [DATA_WIDTH-1:0] r_qsel;
    logic [ACTION_WIDTH-1:0]      r_sel_idx;
    logic signed [PW-1:0]         r_prod;

    logic [DATA_WIDTH-1:0]   r_q;
    logic [ACTION_WIDTH-1:0] r_act_out;
    logic [DATA_WIDTH-1:0]   r_target;
    logic                    r_err;

    logic                         w_ready;
    logic                         w_err;
    logic                         w_acc_load;
    logic                         w_addr_zero;
    logic                         w_in_order;
    logic                         w_is_last;
    logic                         w_sel_bad;
    logic signed [DATA_WIDTH-1:0] w_acc_max;
    logic [ACTION_WIDTH-1:0]      w_acc_idx;
    logic signed [DATA_WIDTH-1:0] w_qsel;
    logic signed [PW-1:0]         w_q_ext;
    logic signed [PW-1:0]         w_g_ext;
    logic signed [PW-1:0]         w_prod;
    logic signed [DATA_WIDTH-1:0] w_scaled;
    logic signed [63:0]           w_sat;
    logic                         w_unused_bits;

    assign w_ready     = (r_state == S_IDLE) || (r_state == S_COLLECT) || (r_state == S_WAIT_CTX);
    assign w_addr_zero = (i_data_addr == '0);
    assign w_in_order  = (i_data_addr == r_cnt);
    assign w_is_last   = (i_data_addr == LAST_ADDR);
    assign w_sel_bad   = (r_mode == MODE_SELECT) && (32'(r_action) >= NUMBER_OF_OUTPUT_NODE);

    q_argmax_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (ACTION_WIDTH)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_acc_load),
        .i_first (w_addr_zero),
        .i_idx   (i_data_addr),
        .i_data  (i_data),
        .o_max   (w_acc_max),
        .o_idx   (w_acc_idx)
    );

    // Q selection and fixed-point scaling: Q * GAMMA, then keep bits [FRAC_BITS +: DATA_WIDTH]
    // which equals (product >>> FRAC_BITS) truncated to the word width.
    assign w_qsel   = (r_mode == MODE_SELECT) ? r_qbuf[r_action] : w_acc_max;
    assign w_q_ext  = PW'(w_qsel);
    assign w_g_ext  = PW'(GAMMA);
    assign w_prod   = w_q_ext * w_g_ext;
    assign w_scaled = r_prod[FRAC_BITS +: DATA_WIDTH];
    assign w_sat    = sat_add(64'(r_reward), 64'(w_scaled), DATA_WIDTH);

    assign w_unused_bits = ^{w_sat[63:DATA_WIDTH], r_prod[FRAC_BITS-1:0],
                             r_prod[PW-1:FRAC_BITS+DATA_WIDTH]};

    // Next-state, sample acceptance and protocol-error decode.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_acc_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_data_valid) begin
                    if (w_addr_zero) begin
                        w_acc_load  = 1'b1;
                        w_state_nxt = S_COLLECT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (i_data_valid) begin
                    if (w_in_order) begin
                        w_acc_load = 1'b1;
                        if (w_is_last) begin
                            w_state_nxt = (r_ctx_held || i_ctx_valid) ? S_MUL : S_WAIT_CTX;
                        end
                    end else if (w_addr_zero) begin
                        w_err      = 1'b1;
                        w_acc_load = 1'b1;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_WAIT_CTX: begin
                // Buffered frame is kept; a new sample here is only flagged.
                if (i_data_valid) begin
                    w_err = 1'b1;
                end
                if (i_ctx_valid) begin
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                if (w_sel_bad) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD:   w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register, expected-address counter and registered error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;
            if (w_acc_load) begin
                r_cnt <= i_data_addr + 1'b1;
            end else if (w_state_nxt == S_IDLE) begin
                r_cnt <= '0;
            end
        end
    end

    // Context latch: last strobe wins, released once the frame result (or error) is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctx_held <= 1'b0;
            r_mode     <= MODE_MAX;
            r_action   <= '0;
            r_reward   <= '0;
            r_done     <= 1'b0;
        end else if (w_ready && i_ctx_valid) begin
            r_ctx_held <= 1'b1;
            r_mode     <= i_mode;
            r_action   <= i_action;
            r_reward   <= i_reward;
            r_done     <= i_done;
        end else if ((r_state == S_OUT) || ((r_state == S_MUL) && w_sel_bad)) begin
            r_ctx_held <= 1'b0;
        end
    end

    // Sample buffer so select mode works whether context arrives before or after the frame.
    always_ff @(posedge clk) begin
        if (w_acc_load) begin
            r_qbuf[i_data_addr] <= i_data;
        end
    end

    // Datapath pipeline: MUL registers Q_sel and product, ADD registers the visible results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qsel    <= '0;
            r_sel_idx <= '0;
            r_prod    <= '0;
            r_q       <= '0;
            r_act_out <= '0;
            r_target  <= '0;
        end else begin
            if (r_state == S_MUL) begin
                r_qsel    <= w_qsel;
                r_sel_idx <= (r_mode == MODE_SELECT) ? r_action : w_acc_idx;
                r_prod    <= w_prod;
            end
            if (r_state == S_ADD) begin
                r_q       <= r_qsel;
                r_act_out <= r_sel_idx;
                r_target  <= r_done ? r_reward : w_sat[DATA_WIDTH-1:0];
            end
        end
    end

    assign o_ready  = w_ready;
    assign o_valid  = (r_state == S_OUT);
    assign o_q      = r_q;
    assign o_action = r_act_out;
    assign o_target = r_target;
    assign o_err    = r_err;

endmodule

// File: tb/tb_target_q_reduce.sv
// Directed self-checking bench for target_q_reduce (N=3, FRAC_BITS=16, GAMMA=62259).
module tb_target_q_reduce;

    logic        clk;
    logic        rst;
    logic        i_data_valid;
    logic [1:0]  i_data_addr;
    logic [31:0] i_data;
    logic        o_ready;
    logic        i_ctx_valid;
    logic        i_mode;
    logic [1:0]  i_action;
    logic [31:0] i_reward;
    logic        i_done;
    logic        o_valid;
    logic [31:0] o_q;
    logic [1:0]  o_action;
    logic [31:0] o_target;
    logic        o_err;

    int tests;
    int failed;

    target_q_reduce #(
        .DATA_WIDTH            (32),
        .FRAC_BITS             (16),
        .NUMBER_OF_OUTPUT_NODE (3),
        .GAMMA                 (62259)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_data_valid (i_data_valid),
        .i_data_addr  (i_data_addr),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .i_ctx_valid  (i_ctx_valid),
        .i_mode       (i_mode),
        .i_action     (i_action),
        .i_reward     (i_reward),
        .i_done       (i_done),
        .o_valid      (o_valid),
        .o_q          (o_q),
        .o_action     (o_action),
        .o_target     (o_target),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_sample(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        i_data_valid = 1'b1;
        i_data_addr  = addr;
        i_data       = data;
        @(negedge clk);
        i_data_valid = 1'b0;
    endtask

    task automatic send_ctx(input logic mode, input logic [1:0] act,
                            input logic [31:0] rew, input logic done);
        @(negedge clk);
        i_ctx_valid = 1'b1;
        i_mode      = mode;
        i_action    = act;
        i_reward    = rew;
        i_done      = done;
        @(negedge clk);
        i_ctx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] q0, input logic [31:0] q1, input logic [31:0] q2);
        send_sample(2'd0, q0);
        send_sample(2'd1, q1);
        send_sample(2'd2, q2);
    endtask

    // Called at the negedge right after the triggering capture edge (cycle T+1).
    task automatic wait_result(input int limit, output int cyc, output bit saw_valid, output bit saw_err);
        cyc       = 1;
        saw_valid = 1'b0;
        saw_err   = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (o_err) saw_err = 1'b1;
            if (o_valid) begin
                saw_valid = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_data_valid = 1'b0; i_data_addr = '0; i_data = '0;
        i_ctx_valid = 1'b0; i_mode = 1'b0; i_action = '0; i_reward = '0; i_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b exp 0", o_valid); end
        tests++; if (o_err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b exp 0", o_err); end
        tests++; if (o_q !== 32'h0) begin failed++; $display("FAIL reset_q: got %h exp 0", o_q); end
        tests++; if (o_action !== 2'd0) begin failed++; $display("FAIL reset_action: got %0d exp 0", o_action); end
        tests++; if (o_target !== 32'h0) begin failed++; $display("FAIL reset_target: got %h exp 0", o_target); end
        tests++; if (o_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b exp 1", o_ready); end
    endtask

    task automatic test_max();
        int cyc; bit v; bit e;
        send_ctx(1'b0, 2'd0, 32'h8000, 1'b0);
        send_frame(32'h10000, 32'h30000, 32'h20000);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL max_valid: got %b exp 1", v); end
        tests++; if (cyc != 3) begin failed++; $display("FAIL max_latency: got %0d exp 3", cyc); end
        tests++; if (e !== 1'b0) begin failed++; $display("FAIL max_err: got %b exp 0", e); end
        tests++; if (o_q !== 32'h30000) begin failed++; $display("FAIL max_q: got %h exp 30000", o_q); end
        tests++; if (o_action !== 2'd1) begin failed++; $display("FAIL max_action: got %0d exp 1", o_action); end
        tests++; if (o_target !== 32'h35999) begin failed++; $display("FAIL max_target: got %h exp 35999", o_target); end
        tests++; if (o_ready !== 1'b0) begin failed++; $display("FAIL max_ready_out: got %b exp 0", o_ready); end
        @(negedge clk);
        tests++; if (o_valid !== 1'b0) begin failed++; $display("FAIL max_one_cycle: got %b exp 0", o_valid); end
        tests++; if (o_ready !== 1'b1) begin failed++; $display("FAIL max_ready_back: got %b exp 1", o_ready); end
        tests++; if (o_target !== 32'h35999) begin failed++; $display("FAIL max_hold: got %h exp 35999", o_target); end
    endtask

    task automatic test_done_tie();
        int cyc; bit v; bit e;
        send_ctx(1'b0, 2'd0, 32'h8000, 1'b1);
        send_frame(32'h10000, 32'h30000, 32'h20000);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL done_valid: got %b exp 1", v); end
        tests++; if (o_target !== 32'h8000) begin failed++; $display("FAIL done_target: got %h exp 8000", o_target); end
        tests++; if (o_q !== 32'h30000) begin failed++; $display("FAIL done_q: got %h exp 30000", o_q); end
        send_ctx(1'b0, 2'd0, 32'h8000, 1'b0);
        send_frame(32'h20000, 32'h20000, 32'h10000);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL tie_valid: got %b exp 1", v); end
        tests++; if (o_action !== 2'd0) begin failed++; $display("FAIL tie_action: got %0d exp 0", o_action); end
        tests++; if (o_q !== 32'h20000) begin failed++; $display("FAIL tie_q: got %h exp 20000", o_q); end
        tests++; if (o_target !== 32'h26666) begin failed++; $display("FAIL tie_target: got %h exp 26666", o_target); end
    endtask

    task automatic test_select();
        int cyc; bit v; bit e;
        send_ctx(1'b1, 2'd2, 32'h8000, 1'b0);
        send_sample(2'd0, 32'h10000);
        repeat (2) @(negedge clk);
        send_sample(2'd1, 32'h30000);
        send_sample(2'd2, 32'h20000);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL sel_valid: got %b exp 1", v); end
        tests++; if (cyc != 3) begin failed++; $display("FAIL sel_latency: got %0d exp 3", cyc); end
        tests++; if (o_q !== 32'h20000) begin failed++; $display("FAIL sel_q: got %h exp 20000", o_q); end
        tests++; if (o_action !== 2'd2) begin failed++; $display("FAIL sel_action: got %0d exp 2", o_action); end
        tests++; if (o_target !== 32'h26666) begin failed++; $display("FAIL sel_target: got %h exp 26666", o_target); end
    endtask

    task automatic test_select_late_ctx();
        int cyc; bit v; bit e; bit bad;
        send_frame(32'h10000, 32'h30000, 32'h20000);
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (o_valid !== 1'b0 || o_ready !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        tests++; if (bad !== 1'b0) begin failed++; $display("FAIL late_wait: got bad=%b exp 0", bad); end
        send_ctx(1'b1, 2'd2, 32'h8000, 1'b0);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL late_valid: got %b exp 1", v); end
        tests++; if (cyc != 3) begin failed++; $display("FAIL late_latency: got %0d exp 3", cyc); end
        tests++; if (o_q !== 32'h20000) begin failed++; $display("FAIL late_q: got %h exp 20000", o_q); end
        tests++; if (o_action !== 2'd2) begin failed++; $display("FAIL late_action: got %0d exp 2", o_action); end
        tests++; if (o_target !== 32'h26666) begin failed++; $display("FAIL late_target: got %h exp 26666", o_target); end
    endtask

    task automatic test_saturation();
        int cyc; bit v; bit e;
        send_ctx(1'b0, 2'd0, 32'h7FFF0000, 1'b0);
        send_frame(32'h7FFF0000, 32'h10000, 32'h0);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL satp_valid: got %b exp 1", v); end
        tests++; if (o_q !== 32'h7FFF0000) begin failed++; $display("FAIL satp_q: got %h exp 7fff0000", o_q); end
        tests++; if (o_target !== 32'h7FFFFFFF) begin failed++; $display("FAIL satp_target: got %h exp 7fffffff", o_target); end
        send_ctx(1'b0, 2'd0, 32'h80000000, 1'b0);
        send_frame(32'h80000000, 32'h80000000, 32'h80000000);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL satn_valid: got %b exp 1", v); end
        tests++; if (o_action !== 2'd0) begin failed++; $display("FAIL satn_action: got %0d exp 0", o_action); end
        tests++; if (o_target !== 32'h80000000) begin failed++; $display("FAIL satn_target: got %h exp 80000000", o_target); end
    endtask

    task automatic test_protocol();
        int cyc; bit v; bit e;
        send_ctx(1'b0, 2'd0, 32'h8000, 1'b0);
        send_sample(2'd0, 32'h10000);
        send_sample(2'd2, 32'h20000);
        tests++; if (o_err !== 1'b1) begin failed++; $display("FAIL ooo_err: got %b exp 1", o_err); end
        @(negedge clk);
        tests++; if (o_err !== 1'b0) begin failed++; $display("FAIL ooo_err_pulse: got %b exp 0", o_err); end
        wait_result(6, cyc, v, e);
        tests++; if (v !== 1'b0) begin failed++; $display("FAIL ooo_no_valid: got %b exp 0", v); end
        send_frame(32'h10000, 32'h30000, 32'h20000);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL ooo_recover_valid: got %b exp 1", v); end
        tests++; if (o_target !== 32'h35999) begin failed++; $display("FAIL ooo_recover_target: got %h exp 35999", o_target); end
        // Sample during context wait: flagged, buffered frame still used.
        send_frame(32'h10000, 32'h30000, 32'h20000);
        send_sample(2'd0, 32'h7FFF0000);
        tests++; if (o_err !== 1'b1) begin failed++; $display("FAIL wait_err: got %b exp 1", o_err); end
        send_ctx(1'b0, 2'd0, 32'h8000, 1'b0);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL wait_valid: got %b exp 1", v); end
        tests++; if (o_q !== 32'h30000) begin failed++; $display("FAIL wait_q: got %h exp 30000", o_q); end
        // Select mode with out-of-range action.
        send_ctx(1'b1, 2'd3, 32'h8000, 1'b0);
        send_frame(32'h10000, 32'h30000, 32'h20000);
        wait_result(8, cyc, v, e);
        tests++; if (v !== 1'b0) begin failed++; $display("FAIL badact_no_valid: got %b exp 0", v); end
        tests++; if (e !== 1'b1) begin failed++; $display("FAIL badact_err: got %b exp 1", e); end
        tests++; if (o_ready !== 1'b1) begin failed++; $display("FAIL badact_ready: got %b exp 1", o_ready); end
    endtask

    task automatic test_midframe_reset();
        int cyc; bit v; bit e;
        send_ctx(1'b0, 2'd0, 32'h8000, 1'b0);
        send_sample(2'd0, 32'h10000);
        send_sample(2'd1, 32'h30000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (o_q !== 32'h0) begin failed++; $display("FAIL mrst_q: got %h exp 0", o_q); end
        tests++; if (o_target !== 32'h0) begin failed++; $display("FAIL mrst_target: got %h exp 0", o_target); end
        tests++; if (o_action !== 2'd0) begin failed++; $display("FAIL mrst_action: got %0d exp 0", o_action); end
        tests++; if (o_ready !== 1'b1) begin failed++; $display("FAIL mrst_ready: got %b exp 1", o_ready); end
        wait_result(6, cyc, v, e);
        tests++; if (v !== 1'b0 || e !== 1'b0) begin failed++; $display("FAIL mrst_quiet: got valid=%b err=%b exp 0 0", v, e); end
        send_ctx(1'b0, 2'd0, 32'h8000, 1'b0);
        send_frame(32'h10000, 32'h30000, 32'h20000);
        wait_result(10, cyc, v, e);
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL mrst_fresh_valid: got %b exp 1", v); end
        tests++; if (o_q !== 32'h30000) begin failed++; $display("FAIL mrst_fresh_q: got %h exp 30000", o_q); end
        tests++; if (o_action !== 2'd1) begin failed++; $display("FAIL mrst_fresh_action: got %0d exp 1", o_action); end
        tests++; if (o_target !== 32'h35999) begin failed++; $display("FAIL mrst_fresh_target: got %h exp 35999", o_target); end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_max();
        test_done_tie();
        test_select();
        test_select_late_ctx();
        test_saturation();
        test_protocol();
        test_midframe_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
